alu_arbiter: RTL and testbench
==============================

// Module: alu_arbiter
// PURPOSE
//  Shares one combinational ALU between two requesters (port 0: execute, port 1: address/branch calc).
//  Arbitrates round-robin, drives the ALU operands, registers the result into one output slot,
//  and returns it to the granted requester under a valid/ready handshake.
//  Sits between the issue logic and the single ALU instance in the core.
// PARAMETERS
//  XLEN  32  operand/result width
//  OPW   3   ALU op-code width (0 ADD,1 SLL,2 SLT,3 SLTU,4 XOR,5 SR,6 OR,7 AND)
// PORTS
//  clk            in   1     clock, rising edge
//  rst            in   1     reset, asynchronous, active-high
//  reqN_valid     in   1     requester N (N=0,1) has an operation
//  reqN_ready     out  1     request N accepted this cycle (combinational grant)
//  reqN_a/_b      in   XLEN  operands
//  reqN_op        in   OPW   ALU op-code
//  reqN_mod       in   1     modifier (arithmetic shift)
//  rspN_valid     out  1     result for requester N available
//  rspN_ready     in   1     requester N takes result
//  rsp_res        out  XLEN  result (shared bus, qualified by rspN_valid)
//  alu_a/_b       out  XLEN  to ALU; alu_op out OPW; alu_mod out 1
//  alu_res        in   XLEN  from ALU (combinational, same cycle)
// BEHAVIOUR
//  - Reset: rsp0/1_valid=0, rsp_res=0, slot EMPTY, last_grant=1 (port 0 wins first tie).
//  - Slot FSM: EMPTY -> FULL on grant; FULL -> EMPTY on rspN_ready with no new grant;
//    FULL -> FULL on drain+grant same cycle (back-to-back, one result per cycle throughput).
//  - Grant allowed when slot EMPTY or owner's rspN_ready=1 this cycle; else both ready=0.
//  - Arbitration: one valid -> it wins; both valid -> port != last_grant; last_grant updates on grant only.
//  - ALU muxed from granted port; no grant -> alu_* driven from port 0 (don't-care, no side effects).
//  - Latency: grant in cycle T -> rspN_valid=1 from T+1; held with rsp_res stable until rspN_ready.
//  - At most one rspN_valid high; owner tag stored with result.
//  - Requester keeps valid and operands stable until ready; dropping valid without ready is legal.
//  - rspN_ready while rspN_valid=0 ignored.
//  - rst mid-operation: pending result discarded, slot EMPTY, no rsp pulse after release.
//  - Width rules: result stored as received from ALU, no extension or truncation.
// CONFIGURATION
//  ALU_ARB_PERF_EN defined: adds outputs grant0_cnt, grant1_cnt, stall_cnt (32b each, reset 0,
//    wrap at 2^32); grantN_cnt +1 per grant to port N; stall_cnt +1 per cycle with any valid and no grant.
//  Not defined: counters and their ports absent; arbitration/timing identical.
// STRUCTURE
//  Shared package alu_pkg: op-code localparams (ADD..AND), XLEN default, port-id type (1b).
//  Sub-module rr_arb2: 2-way round-robin arbiter (valid0/1, enable, last_grant state -> grant0/1);
//    slot FSM, operand mux and counters stay in alu_arbiter.
// TESTING
//  - Reset: rst=1 mid-run -> all rsp valid 0, rsp_res=0, counters 0; first tie after release -> port 0.
//  - Single: req0 ADD a=5 b=-3 -> req0_ready=1 same cycle, rsp0_valid next cycle, rsp_res=2.
//  - Tie alternation: both valid every cycle, rsp ready=1 -> grants 0,1,0,1; port1 SR mod=1
//    a=0x80000000 b=4 -> 0xF8000000.
//  - Back-pressure: rsp0_ready=0 for 3 cycles -> both reqN_ready=0, rsp_res stable; ready=1 ->
//    drain and new grant same cycle.
//  - Withdraw: req1_valid dropped before grant -> no rsp1_valid, last_grant unchanged.
//  - PERF (ALU_ARB_PERF_EN): 10 grants port 0, 6 port 1, 3 stall cycles -> 10/6/3.

Source files
------------

// File: rtl/alu_pkg.sv
// -----------------------------------------------------------------------------
// alu_pkg
// Shared definitions for the ALU arbiter slice: default widths, ALU op-codes,
// the requester id type and the result-slot state encoding.
// No ports (package).
// -----------------------------------------------------------------------------
package alu_pkg;

    localparam int XLEN_DEF = 32;
    localparam int OPW_DEF  = 3;

    // ALU op-codes
    localparam logic [2:0] OP_ADD  = 3'd0;
    localparam logic [2:0] OP_SLL  = 3'd1;
    localparam logic [2:0] OP_SLT  = 3'd2;
    localparam logic [2:0] OP_SLTU = 3'd3;
    localparam logic [2:0] OP_XOR  = 3'd4;
    localparam logic [2:0] OP_SR   = 3'd5;
    localparam logic [2:0] OP_OR   = 3'd6;
    localparam logic [2:0] OP_AND  = 3'd7;

    // Requester id: 0 = execute, 1 = address/branch calc
    typedef logic port_id_t;

    // Result-slot states
    localparam logic [0:0] SLOT_EMPTY = 1'b0;
    localparam logic [0:0] SLOT_FULL  = 1'b1;

endpackage

// File: rtl/alu_arbiter_if.sv
// -----------------------------------------------------------------------------
// alu_arbiter_if
// Bundles the two requester handshakes, the shared response bus and the ALU
// operand/result wires seen by alu_arbiter.
//   slave  : arbiter view (takes requests, drives ready/response and ALU inputs)
//   master : requester + ALU view (drives requests, response ready, ALU result)
// -----------------------------------------------------------------------------
interface alu_arbiter_if
    import alu_pkg::*;
#(
    parameter int XLEN = XLEN_DEF,
    parameter int OPW  = OPW_DEF
);
    // requester 0
    logic            req0_valid;
    logic            req0_ready;
    logic [XLEN-1:0] req0_a;
    logic [XLEN-1:0] req0_b;
    logic [OPW-1:0]  req0_op;
    logic            req0_mod;
    // requester 1
    logic            req1_valid;
    logic            req1_ready;
    logic [XLEN-1:0] req1_a;
    logic [XLEN-1:0] req1_b;
    logic [OPW-1:0]  req1_op;
    logic            req1_mod;
    // responses (shared result bus)
    logic            rsp0_valid;
    logic            rsp0_ready;
    logic            rsp1_valid;
    logic            rsp1_ready;
    logic [XLEN-1:0] rsp_res;
    // ALU
    logic [XLEN-1:0] alu_a;
    logic [XLEN-1:0] alu_b;
    logic [OPW-1:0]  alu_op;
    logic            alu_mod;
    logic [XLEN-1:0] alu_res;

    modport slave (
        input  req0_valid, req0_a, req0_b, req0_op, req0_mod,
        input  req1_valid, req1_a, req1_b, req1_op, req1_mod,
        output req0_ready, req1_ready,
        output rsp0_valid, rsp1_valid, rsp_res,
        input  rsp0_ready, rsp1_ready,
        output alu_a, alu_b, alu_op, alu_mod,
        input  alu_res
    );

    modport master (
        output req0_valid, req0_a, req0_b, req0_op, req0_mod,
        output req1_valid, req1_a, req1_b, req1_op, req1_mod,
        input  req0_ready, req1_ready,
        input  rsp0_valid, rsp1_valid, rsp_res,
        output rsp0_ready, rsp1_ready,
        input  alu_a, alu_b, alu_op, alu_mod,
        output alu_res
    );

endinterface

// File: rtl/alu_arbiter_rr_arb2.sv
// -----------------------------------------------------------------------------
// rr_arb2
// Two-way round-robin arbiter with its own last-grant state.
// Ports:
//   clk, rst            clock, async active-high reset
//   valid0_i, valid1_i  requests
//   enable_i            granting allowed this cycle
//   grant0_o, grant1_o  one-hot (or zero) grant, combinational
// last_grant resets to 1 so port 0 wins the first tie, and only moves when a
// grant is actually issued (a withdrawn request leaves it untouched).
// -----------------------------------------------------------------------------
module rr_arb2
    import alu_pkg::*;
(
    input  logic clk,
    input  logic rst,
    input  logic valid0_i,
    input  logic valid1_i,
    input  logic enable_i,
    output logic grant0_o,
    output logic grant1_o
);

    port_id_t last_q, last_d;

    always_comb begin
        // on a tie, the port that was not granted last goes first
        grant0_o = enable_i & valid0_i & (~valid1_i | last_q);
        grant1_o = enable_i & valid1_i & (~valid0_i | ~last_q);
        last_d   = last_q;
        if (grant0_o)      last_d = 1'b0;
        else if (grant1_o) last_d = 1'b1;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) last_q <= 1'b1;
        else     last_q <= last_d;
    end

endmodule

// File: rtl/alu_arbiter.sv
// -----------------------------------------------------------------------------
// alu_arbiter
// Shares one combinational ALU between requester 0 (execute) and requester 1
// (address/branch calc). Round-robin grant, operands muxed to the ALU, result
// captured into a single output slot tagged with its owner and handed back
// under valid/ready. A slot drain and a new grant may happen in the same
// cycle, so throughput is one result per cycle.
// Ports:
//   clk, rst     clock, async active-high reset
//   bus          alu_arbiter_if.slave (requests, responses, ALU wires)
//   grant0_cnt, grant1_cnt, stall_cnt   (only with ALU_ARB_PERF_EN defined)
//                grants per port and cycles with a request but no grant
// Optional feature macro: ALU_ARB_PERF_EN
// -----------------------------------------------------------------------------
module alu_arbiter
    import alu_pkg::*;
#(
    parameter int XLEN = XLEN_DEF,
    parameter int OPW  = OPW_DEF
) (
    input  logic         clk,
    input  logic         rst,
    alu_arbiter_if.slave bus
`ifdef ALU_ARB_PERF_EN
    ,
    output logic [31:0]  grant0_cnt,
    output logic [31:0]  grant1_cnt,
    output logic [31:0]  stall_cnt
`endif
);

    logic [0:0]      state_q, state_d;
    port_id_t        owner_q, owner_d;
    logic [XLEN-1:0] res_q, res_d;

    logic            owner_rdy;
    logic            drain;
    logic            can_grant;
    logic            grant0, grant1;
    logic [OPW-1:0]  op_sel;

    // The slot frees up this cycle if its owner is taking the result.
    always_comb begin
        owner_rdy = owner_q ? bus.rsp1_ready : bus.rsp0_ready;
        drain     = (state_q == SLOT_FULL) & owner_rdy;
        can_grant = (state_q == SLOT_EMPTY) | drain;
    end

    rr_arb2 u_arb (
        .clk      (clk),
        .rst      (rst),
        .valid0_i (bus.req0_valid),
        .valid1_i (bus.req1_valid),
        .enable_i (can_grant),
        .grant0_o (grant0),
        .grant1_o (grant1)
    );

    assign bus.req0_ready = grant0;
    assign bus.req1_ready = grant1;

    // Operand mux: port 0 is the idle default so the ALU sees stable inputs.
    always_comb begin
        op_sel      = grant1 ? bus.req1_op  : bus.req0_op;
        bus.alu_a   = grant1 ? bus.req1_a   : bus.req0_a;
        bus.alu_b   = grant1 ? bus.req1_b   : bus.req0_b;
        bus.alu_mod = grant1 ? bus.req1_mod : bus.req0_mod;
        bus.alu_op  = op_sel;
    end

    // Slot FSM: a grant always (re)fills the slot, even while draining.
    always_comb begin
        state_d = state_q;
        owner_d = owner_q;
        res_d   = res_q;
        if (grant0 | grant1) begin
            state_d = SLOT_FULL;
            owner_d = grant1;
            res_d   = bus.alu_res;
        end else if (drain) begin
            state_d = SLOT_EMPTY;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= SLOT_EMPTY;
            owner_q <= 1'b0;
            res_q   <= '0;
        end else begin
            state_q <= state_d;
            owner_q <= owner_d;
            res_q   <= res_d;
        end
    end

    assign bus.rsp0_valid = (state_q == SLOT_FULL) & ~owner_q;
    assign bus.rsp1_valid = (state_q == SLOT_FULL) &  owner_q;
    assign bus.rsp_res    = res_q;

`ifdef ALU_ARB_PERF_EN
    logic [31:0] g0_cnt_q, g1_cnt_q, st_cnt_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            g0_cnt_q <= '0;
            g1_cnt_q <= '0;
            st_cnt_q <= '0;
        end else begin
            if (grant0) g0_cnt_q <= g0_cnt_q + 32'd1;
            if (grant1) g1_cnt_q <= g1_cnt_q + 32'd1;
            if ((bus.req0_valid | bus.req1_valid) & ~(grant0 | grant1))
                st_cnt_q <= st_cnt_q + 32'd1;
        end
    end

    assign grant0_cnt = g0_cnt_q;
    assign grant1_cnt = g1_cnt_q;
    assign stall_cnt  = st_cnt_q;
`endif

endmodule

// File: tb/tb_alu_arbiter.sv
// -----------------------------------------------------------------------------
// tb_alu_arbiter
// Directed scenarios followed by randomized traffic against a transaction-level
// model of the arbiter (pending-result slot, last winner, results computed
// from the request operands with plain arithmetic).
// -----------------------------------------------------------------------------
module tb_alu_arbiter;
    import alu_pkg::*;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    alu_arbiter_if #(.XLEN(32), .OPW(3)) bus ();

`ifdef ALU_ARB_PERF_EN
    logic [31:0] g0c, g1c, stc;
`endif

    alu_arbiter #(.XLEN(32), .OPW(3)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
`ifdef ALU_ARB_PERF_EN
        ,
        .grant0_cnt (g0c),
        .grant1_cnt (g1c),
        .stall_cnt  (stc)
`endif
    );

    function automatic logic [31:0] ref_alu(input logic [2:0] op, input logic [31:0] a,
                                            input logic [31:0] b, input logic m);
        int sh;
        sh = int'(b % 32);
        case (op)
            OP_ADD:  return a + b;
            OP_SLL:  return a << sh;
            OP_SLT:  return ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
            OP_SLTU: return (a < b) ? 32'd1 : 32'd0;
            OP_XOR:  return a ^ b;
            OP_SR: begin
                if (m) return $signed(a) >>> sh;
                return a >> sh;
            end
            OP_OR:   return a | b;
            default: return a & b;
        endcase
    endfunction

    // The external ALU
    always_comb bus.alu_res = ref_alu(bus.alu_op, bus.alu_a, bus.alu_b, bus.alu_mod);

    int checks = 0;
    int failures = 0;

    // model state
    logic        m_full, m_owner, m_last;
    logic [31:0] m_res;
    int unsigned m_g0, m_g1, m_st;
    // observations from the last step
    logic        obs_any, obs_g1;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        m_full = 1'b0; m_owner = 1'b0; m_last = 1'b1; m_res = '0;
        m_g0 = 0; m_g1 = 0; m_st = 0;
    endtask

    task automatic set0(input logic v, input logic [2:0] op, input logic [31:0] a,
                        input logic [31:0] b, input logic m);
        bus.req0_valid = v; bus.req0_op = op; bus.req0_a = a; bus.req0_b = b; bus.req0_mod = m;
    endtask

    task automatic set1(input logic v, input logic [2:0] op, input logic [31:0] a,
                        input logic [31:0] b, input logic m);
        bus.req1_valid = v; bus.req1_op = op; bus.req1_a = a; bus.req1_b = b; bus.req1_mod = m;
    endtask

    // One clock: check combinational + registered outputs mid-cycle, then advance model.
    task automatic step();
        logic blocked, e0, e1, v0, v1;
        @(negedge clk);
        v0 = bus.req0_valid;
        v1 = bus.req1_valid;
        blocked = m_full && !(m_owner ? bus.rsp1_ready : bus.rsp0_ready);
        e0 = 1'b0; e1 = 1'b0;
        if (!blocked) begin
            if (v0 && v1) begin
                if (m_last) e0 = 1'b1; else e1 = 1'b1;
            end else if (v0) e0 = 1'b1;
            else if (v1) e1 = 1'b1;
        end
        chk("req0_ready", 32'(bus.req0_ready), 32'(e0));
        chk("req1_ready", 32'(bus.req1_ready), 32'(e1));
        chk("rsp0_valid", 32'(bus.rsp0_valid), 32'(m_full && !m_owner));
        chk("rsp1_valid", 32'(bus.rsp1_valid), 32'(m_full && m_owner));
        if (m_full) chk("rsp_res", bus.rsp_res, m_res);
        obs_any = bus.req0_ready | bus.req1_ready;
        obs_g1  = bus.req1_ready;
        if (e0 || e1) begin
            m_full  = 1'b1;
            m_owner = e1;
            m_last  = e1;
            m_res   = e1 ? ref_alu(bus.req1_op, bus.req1_a, bus.req1_b, bus.req1_mod)
                         : ref_alu(bus.req0_op, bus.req0_a, bus.req0_b, bus.req0_mod);
            if (e1) m_g1++; else m_g0++;
        end else begin
            if (m_full && (m_owner ? bus.rsp1_ready : bus.rsp0_ready)) m_full = 1'b0;
            if (v0 || v1) m_st++;
        end
        @(posedge clk);
        #1;
    endtask

    task automatic check_reset_outputs(input string tag);
        chk({tag, "_rsp0_valid"}, 32'(bus.rsp0_valid), 32'd0);
        chk({tag, "_rsp1_valid"}, 32'(bus.rsp1_valid), 32'd0);
        chk({tag, "_rsp_res"}, bus.rsp_res, 32'd0);
`ifdef ALU_ARB_PERF_EN
        chk({tag, "_grant0_cnt"}, g0c, 32'd0);
        chk({tag, "_grant1_cnt"}, g1c, 32'd0);
        chk({tag, "_stall_cnt"}, stc, 32'd0);
`endif
    endtask

    initial begin
        logic tie_seq [4];
        rst = 1'b1;
        set0(1'b0, OP_ADD, '0, '0, 1'b0);
        set1(1'b0, OP_ADD, '0, '0, 1'b0);
        bus.rsp0_ready = 1'b0;
        bus.rsp1_ready = 1'b0;
        model_reset();
        obs_any = 1'b0; obs_g1 = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        check_reset_outputs("reset");
        rst = 1'b0;

        // Tie alternation from reset: 0,1,0,1; port 1 performs an arithmetic shift right
        bus.rsp0_ready = 1'b1; bus.rsp1_ready = 1'b1;
        set0(1'b1, OP_ADD, 32'd10, 32'd20, 1'b0);
        set1(1'b1, OP_SR, 32'h8000_0000, 32'd4, 1'b1);
        for (int i = 0; i < 4; i++) begin
            step();
            tie_seq[i] = obs_g1;
            if (i == 1) chk("tie_sra_res", bus.rsp_res, 32'hF800_0000);
        end
        chk("tie_g0", 32'(tie_seq[0]), 32'd0);
        chk("tie_g1", 32'(tie_seq[1]), 32'd1);
        chk("tie_g2", 32'(tie_seq[2]), 32'd0);
        chk("tie_g3", 32'(tie_seq[3]), 32'd1);

        // Single request on port 0: ADD 5 + -3
        set1(1'b0, OP_ADD, '0, '0, 1'b0);
        set0(1'b1, OP_ADD, 32'd5, 32'hFFFF_FFFD, 1'b0);
        step();
        chk("single_granted0", 32'(obs_any & ~obs_g1), 32'd1);
        chk("single_rsp0_valid", 32'(bus.rsp0_valid), 32'd1);
        chk("single_res", bus.rsp_res, 32'd2);

        // Back-pressure: owner not ready for 3 cycles, nothing granted, result held
        bus.rsp0_ready = 1'b0;
        set0(1'b1, OP_XOR, 32'h0F0F_0000, 32'h00FF_00FF, 1'b0);
        set1(1'b1, OP_OR, 32'h1234_0000, 32'h0000_5678, 1'b0);
        for (int i = 0; i < 3; i++) begin
            step();
            chk("bp_no_grant", 32'(obs_any), 32'd0);
            chk("bp_res_stable", bus.rsp_res, 32'd2);
        end
        bus.rsp0_ready = 1'b1;
        step();  // drain + new grant, port 1 wins (port 0 went last)
        chk("bp_regrant_port1", 32'(obs_g1), 32'd1);
        chk("bp_rsp1_valid", 32'(bus.rsp1_valid), 32'd1);
        chk("bp_or_res", bus.rsp_res, 32'h1234_5678);

        // Port 0 alone so that it becomes the last winner
        set1(1'b0, OP_ADD, '0, '0, 1'b0);
        set0(1'b1, OP_SLT, 32'hFFFF_FFFF, 32'd1, 1'b0);
        step();
        chk("slt_res", bus.rsp_res, 32'd1);

        // Withdraw: port 1 asks while blocked, then drops before any grant
        bus.rsp0_ready = 1'b0;
        set0(1'b0, OP_ADD, '0, '0, 1'b0);
        set1(1'b1, OP_SLTU, 32'hFFFF_FFFF, 32'd1, 1'b0);
        step();
        set1(1'b0, OP_SLTU, 32'hFFFF_FFFF, 32'd1, 1'b0);
        bus.rsp0_ready = 1'b1;
        step();
        chk("wd_no_rsp1", 32'(bus.rsp1_valid), 32'd0);
        chk("wd_no_rsp0", 32'(bus.rsp0_valid), 32'd0);
        set0(1'b1, OP_AND, 32'hFF00_FF00, 32'h0FF0_0FF0, 1'b0);
        set1(1'b1, OP_SLL, 32'h0000_0001, 32'd31, 1'b0);
        step();  // last winner still port 0 -> port 1 takes the tie
        chk("wd_tie_port1", 32'(obs_g1), 32'd1);
        chk("wd_sll_res", bus.rsp_res, 32'h8000_0000);

        // Randomized traffic
        for (int n = 0; n < 400; n++) begin
            set0($urandom_range(0, 9) < 7, 3'($urandom), $urandom,
                 ($urandom_range(0, 1) == 1) ? 32'($urandom_range(0, 40)) : $urandom, 1'($urandom));
            set1($urandom_range(0, 9) < 7, 3'($urandom), $urandom,
                 ($urandom_range(0, 1) == 1) ? 32'($urandom_range(0, 40)) : $urandom, 1'($urandom));
            bus.rsp0_ready = $urandom_range(0, 9) < 7;
            bus.rsp1_ready = $urandom_range(0, 9) < 7;
            step();
        end

        // Mid-run reset with a pending result: asynchronous clear, no pulse afterwards
        set0(1'b1, OP_ADD, 32'd7, 32'd8, 1'b0);
        bus.rsp0_ready = 1'b1; bus.rsp1_ready = 1'b1;
        step();
        bus.rsp0_ready = 1'b0;
        set0(1'b0, OP_ADD, '0, '0, 1'b0);
        set1(1'b0, OP_ADD, '0, '0, 1'b0);
        #2;
        rst = 1'b1;
        #1;
        check_reset_outputs("midrst");
        model_reset();
        @(posedge clk);
        #1;
        rst = 1'b0;
        bus.rsp0_ready = 1'b1;
        step();
        chk("midrst_no_pulse", 32'(bus.rsp0_valid | bus.rsp1_valid), 32'd0);
        set0(1'b1, OP_ADD, 32'd1, 32'd1, 1'b0);
        set1(1'b1, OP_ADD, 32'd2, 32'd2, 1'b0);
        step();
        chk("midrst_tie_port0", 32'(obs_any & ~obs_g1), 32'd1);

        // Counter scenario: 10 grants port 0, 6 grants port 1, 3 stall cycles
        set0(1'b0, OP_ADD, '0, '0, 1'b0);
        set1(1'b0, OP_ADD, '0, '0, 1'b0);
        @(posedge clk);
        rst = 1'b1;
        model_reset();
        @(posedge clk);
        #1;
        rst = 1'b0;
        bus.rsp0_ready = 1'b1; bus.rsp1_ready = 1'b1;
        for (int i = 0; i < 10; i++) begin
            set0(1'b1, OP_ADD, 32'(i), 32'd100, 1'b0);
            step();
        end
        set0(1'b0, OP_ADD, '0, '0, 1'b0);
        for (int i = 0; i < 6; i++) begin
            set1(1'b1, OP_XOR, 32'(i), 32'hA5A5_A5A5, 1'b0);
            step();
        end
        set1(1'b0, OP_ADD, '0, '0, 1'b0);
        bus.rsp1_ready = 1'b0;
        set0(1'b1, OP_OR, 32'd3, 32'd4, 1'b0);
        repeat (3) step();
        chk("perf_model_g0", 32'(m_g0), 32'd10);
        chk("perf_model_g1", 32'(m_g1), 32'd6);
        chk("perf_model_st", 32'(m_st), 32'd3);
`ifdef ALU_ARB_PERF_EN
        chk("grant0_cnt", g0c, 32'd10);
        chk("grant1_cnt", g1c, 32'd6);
        chk("stall_cnt", stc, 32'd3);
`endif

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
